// File: rtl/int_to_flop.sv
// int_to_flop: serial two's-complement integer -> 13-bit flop {sign, mant[7:0], exp[3:0]},
// normalizing one bit per clock. Define INT_TO_FLOP_ROUND_EN for a half-up rounding stage.
module int_to_flop #(
  parameter int IN_W = 16  // legal 9..16; the exponent field tops out at IN_W-1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [12:0]     result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]      EXP_TOP = 4'(IN_W - 1);
  localparam logic [IN_W-1:0] ONE     = IN_W'(1);

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic [IN_W-1:0] mag_q, mag_d;
  logic [3:0]      exp_cnt_q, exp_cnt_d;
  logic [12:0]     result_q, result_d;
`ifdef INT_TO_FLOP_ROUND_EN
  logic [8:0]      mant_inc;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_cnt_d = exp_cnt_q;
    result_d  = result_q;
`ifdef INT_TO_FLOP_ROUND_EN
    mant_inc  = {1'b0, mag_q[IN_W-1 -: 8]} + {8'd0, mag_q[IN_W-9]};
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sign_d    = in_data[IN_W-1];
          // Unsigned magnitude keeps the most negative input exact (e.g. 0x8000).
          mag_d     = in_data[IN_W-1] ? (~in_data) + ONE : in_data;
          exp_cnt_d = EXP_TOP;
          state_d   = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          sign_d   = 1'b0;
          result_d = '0;
          state_d  = DONE;
        end else if (mag_q[IN_W-1]) begin
`ifdef INT_TO_FLOP_ROUND_EN
          state_d  = ROUND;
`else
          result_d = {sign_q, mag_q[IN_W-1 -: 8], exp_cnt_q};
          state_d  = DONE;
`endif
        end else begin
          mag_d     = mag_q << 1;
          exp_cnt_d = exp_cnt_q - 4'd1;
        end
      end
`ifdef INT_TO_FLOP_ROUND_EN
      ROUND: begin
        // Mantissa carry renormalizes to 0x80 one exponent up, or saturates at the top.
        if (mant_inc[8]) begin
          if (exp_cnt_q == 4'hF) begin
            result_d = {sign_q, 8'hFF, 4'hF};
          end else begin
            result_d = {sign_q, 8'h80, exp_cnt_q + 4'd1};
          end
        end else begin
          result_d = {sign_q, mant_inc[7:0], exp_cnt_q};
        end
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_cnt_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_cnt_q <= exp_cnt_d;
      result_q  <= result_d;
    end
  end

endmodule
